// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code step monitor: FSM state, the
// generic Gray-to-binary decode function and the good-step counter width.
package gray_pkg;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Widest word the decode helper handles; narrower words are zero-extended.
  localparam int MAX_W = 32;

  // good_cnt must hold LOCK_LEN for any legal LOCK_LEN (1..255).
  localparam int LOCK_LEN_MAX = 255;
  localparam int GOOD_CNT_W   = $clog2(LOCK_LEN_MAX + 1);

  // bin[MSB] = g[MSB]; bin[i] = bin[i+1] ^ g[i]. Leading zeros decode to zeros.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit Gray-to-binary decoder, the inverse of binaryToGray.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(MAX_W'(gray)));

endmodule

// File: rtl/gray_step_monitor.sv
// Samples a Gray-code stream, decodes it and checks consecutive samples are
// single +/-1 steps. Optional macro GRAY_STRICT_DIR_EN also flags reversals.
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     gray_in,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_err,
  output logic                 dir_up,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshake: gray_in is consumed on every edge where in_valid=1 (no
  // backpressure); out_valid is in_valid delayed by exactly one cycle.

  state_t                state, state_n;
  logic [WIDTH-1:0]      cur_bin, prev, prev_n, diff;
  logic [GOOD_CNT_W-1:0] good_cnt, good_cnt_n;
  logic                  dir_set, dir_set_n;
  logic                  bad_step, is_up;
  logic                  step_err_n, dir_up_n, locked_n;
  logic [WIDTH-1:0]      bin_out_n;
  logic [ERR_CNT_W-1:0]  err_count_n;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (cur_bin)
  );

  assign diff  = cur_bin - prev;
  assign is_up = (diff == WIDTH'(1));

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    good_cnt_n  = good_cnt;
    dir_set_n   = dir_set;
    bin_out_n   = bin_out;
    step_err_n  = 1'b0;
    dir_up_n    = dir_up;
    locked_n    = locked;
    err_count_n = err_count;
    bad_step    = 1'b0;
    if (in_valid) begin
      prev_n    = cur_bin;
      bin_out_n = cur_bin;
      if (state == ACQ) begin
        state_n    = TRACK;
        good_cnt_n = '0;
        dir_set_n  = 1'b0;
        locked_n   = 1'b0;
      end else if (diff == '0) begin
        bad_step = 1'b0;
      end else if (is_up || diff == {WIDTH{1'b1}}) begin
        dir_up_n = is_up;
`ifdef GRAY_STRICT_DIR_EN
        bad_step  = dir_set && (is_up != dir_up);
        dir_set_n = 1'b1;
`endif
        if (!bad_step) begin
          if (good_cnt != GOOD_CNT_W'(LOCK_LEN)) good_cnt_n = good_cnt + 1'b1;
          if (good_cnt_n == GOOD_CNT_W'(LOCK_LEN)) locked_n = 1'b1;
        end
      end else begin
        bad_step = 1'b1;
      end
      // An error restarts lock acquisition and forgets the reference direction.
      if (bad_step) begin
        step_err_n = 1'b1;
        good_cnt_n = '0;
        locked_n   = 1'b0;
        dir_set_n  = 1'b0;
        if (err_count != {ERR_CNT_W{1'b1}}) err_count_n = err_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACQ;
      prev      <= '0;
      good_cnt  <= '0;
      dir_set   <= 1'b0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      step_err  <= 1'b0;
      dir_up    <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      good_cnt  <= good_cnt_n;
      dir_set   <= dir_set_n;
      out_valid <= in_valid;
      bin_out   <= bin_out_n;
      step_err  <= step_err_n;
      dir_up    <= dir_up_n;
      locked    <= locked_n;
      err_count <= err_count_n;
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// Randomized self-checking bench for gray_step_monitor with an integer
// reference model; honours GRAY_STRICT_DIR_EN when defined.
module tb_gray_step_monitor;

  localparam int WIDTH     = 4;
  localparam int ERR_CNT_W = 8;
  localparam int LOCK_LEN  = 4;
  localparam int N         = 1 << WIDTH;
  localparam int EXP_W     = 4 + WIDTH + ERR_CNT_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     gray_in = '0;
  logic                 out_valid;
  logic [WIDTH-1:0]     bin_out;
  logic                 step_err;
  logic                 dir_up;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  int tests = 0;
  int failed = 0;

  gray_step_monitor #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .LOCK_LEN(LOCK_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .step_err  (step_err),
    .dir_up    (dir_up),
    .locked    (locked),
    .err_count (err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state (plain integers, spec rules)
  bit m_track, m_locked, m_dir, m_dirset, m_ov, m_se;
  int m_prev, m_good, m_err, m_bin;
  logic [EXP_W-1:0] exp_q[$];
  int last_val = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_track = 0; m_locked = 0; m_dir = 0; m_dirset = 0; m_ov = 0; m_se = 0;
    m_prev = 0; m_good = 0; m_err = 0; m_bin = 0;
  endfunction

  function automatic void model_step(bit v, int cur);
    int d;
    bit err;
    m_ov = v;
    m_se = 0;
    if (!v) return;
    m_bin = cur;
    err = 0;
    if (!m_track) begin
      m_track = 1; m_good = 0; m_locked = 0; m_dirset = 0;
    end else begin
      d = ((cur - m_prev) % N + N) % N;
      if (d == 1 || d == N - 1) begin
`ifdef GRAY_STRICT_DIR_EN
        if (m_dirset && (m_dir != (d == 1))) err = 1;
        m_dirset = 1;
`endif
        m_dir = (d == 1);
        if (!err) begin
          if (m_good < LOCK_LEN) m_good++;
          if (m_good == LOCK_LEN) m_locked = 1;
        end
      end else if (d != 0) begin
        err = 1;
      end
    end
    if (err) begin
      m_se = 1; m_good = 0; m_locked = 0; m_dirset = 0;
      if (m_err < (1 << ERR_CNT_W) - 1) m_err++;
    end
    m_prev = cur;
  endfunction

  function automatic logic [EXP_W-1:0] model_pack();
    return {m_ov, WIDTH'(m_bin), m_se, m_dir, m_locked, ERR_CNT_W'(m_err)};
  endfunction

  // scoreboard: pop the expected word and compare each field
  task automatic score();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_val("out_valid", int'(out_valid), int'(e[EXP_W-1]));
    check_val("bin_out",   int'(bin_out),   int'(e[EXP_W-2 -: WIDTH]));
    check_val("step_err",  int'(step_err),  int'(e[ERR_CNT_W+2]));
    check_val("dir_up",    int'(dir_up),    int'(e[ERR_CNT_W+1]));
    check_val("locked",    int'(locked),    int'(e[ERR_CNT_W]));
    check_val("err_count", int'(err_count), int'(e[ERR_CNT_W-1:0]));
  endtask

  // driver tasks: drive on negedge, check 1 time unit after posedge
  task automatic drive(input bit v, input int val);
    logic [WIDTH-1:0] b;
    @(negedge clk);
    b        = WIDTH'(val);
    in_valid = v;
    gray_in  = v ? (b ^ (b >> 1)) : WIDTH'($urandom_range(0, N - 1));
    if (v) last_val = val;
    model_step(v, val);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    score();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    gray_in  = WIDTH'($urandom_range(0, N - 1));
    model_reset();
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    score();
    rst = 1'b0;
  endtask

  initial begin
    int r, v;
    do_reset();

    // ascending ramp, lock on the 5th sample
    for (int i = 0; i < N; i++) begin
      drive(1, i);
      if (i == 3) check_val("t1_not_locked_yet", int'(locked), 0);
      if (i == 4) check_val("t1_locked_5th", int'(locked), 1);
    end
    check_val("t1_dir_up", int'(dir_up), 1);

    // wrap 15 -> 0
    drive(1, 15);
    drive(1, 0);
    check_val("t2_wrap_noerr", int'(step_err), 0);
    check_val("t2_locked", int'(locked), 1);

    // illegal 0 -> 2, then good step to 3
    drive(1, 0);
    drive(1, 2);
    check_val("t3_err", int'(step_err), 1);
    check_val("t3_cnt", int'(err_count), 1);
    drive(1, 3);
    check_val("t3_err_pulse", int'(step_err), 0);

    // descending 7,6,5
    drive(1, 7);
    drive(1, 6);
    drive(1, 5);
`ifndef GRAY_STRICT_DIR_EN
    check_val("t4_dir_down", int'(dir_up), 0);
`endif

    // repeat 4,4 then a 3-cycle gap
    drive(1, 4);
    drive(1, 4);
    for (int i = 0; i < 3; i++) drive(0, 0);
    check_val("t5_hold_bin", int'(bin_out), 4);

    // 300 illegal jumps saturate err_count
    for (int i = 0; i < 300; i++) drive(1, (i % 2) * 8);
    check_val("t6_sat", int'(err_count), 255);
    do_reset();
    check_val("t6_rst_cnt", int'(err_count), 0);
    drive(1, 9);
    check_val("t6_first_unchecked", int'(step_err), 0);

    // randomized stream
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 14) drive(0, 0);
      else begin
        r = $urandom_range(0, 99);
        if (r < 40)      v = (last_val + 1) % N;
        else if (r < 70) v = (last_val + N - 1) % N;
        else if (r < 80) v = last_val;
        else             v = $urandom_range(0, N - 1);
        drive(1, v);
      end
    end

    check_val("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
